xnor_bist: RTL

Self-test sequencer for the mux-based XNOR gate (`mux2_1`). It drives the gate's `a`/`b` inputs through all four input combinations and samples the gate's `out` after a programmable settle time. It compares each sample against the XNOR truth table and reports pass/fail, an error count and the first failing vector. It sits directly around the gate in silicon, as its stimulus source and result consumer, and replaces the free-running testbench stimulus with a synthesizable, clocked equivalent.

---
 rtl/xnor_bist.sv | 121 ++++++++++++
 1 files changed

// File: rtl/xnor_bist.sv
// xnor_bist: clocked self-test sequencer for the mux2_1 XNOR gate.
// Define XNOR_BIST_FAIL_MASK_EN to add the per-vector fail_mask output.
module xnor_bist #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [1:0] first_fail
`ifdef XNOR_BIST_FAIL_MASK_EN
  ,
  output logic [3:0] fail_mask
`endif
);

  // state | meaning
  // IDLE  | waiting for start, a/b parked at 00
  // HOLD  | vector driven, settle counter running, sample at terminal count
  // DONE  | one-cycle done pulse, pass already updated
  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [7:0] LAST_LOOP   = 8'(LOOPS - 1);

  state_t     state, state_nxt;
  logic [1:0] vec;
  logic [3:0] settle_cnt;
  logic [7:0] loop_cnt;
  logic       accept;
  logic       sample;
  logic       mismatch;
  logic       last_vec;

  assign a        = vec[1];
  assign b        = vec[0];
  assign mismatch = (dut_out != ~(vec[1] ^ vec[0]));
  assign last_vec = (vec == 2'b11) && (loop_cnt == LAST_LOOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    sample    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        busy = 1'b1;
        if (settle_cnt == 4'd0) begin
          sample = 1'b1;
          if (last_vec) state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec        <= 2'b00;
      settle_cnt <= 4'd0;
      loop_cnt   <= 8'd0;
      err_count  <= 8'd0;
      first_fail <= 2'b00;
      pass       <= 1'b0;
    end else if (accept) begin
      vec        <= 2'b00;
      settle_cnt <= SETTLE_LOAD;
      loop_cnt   <= 8'd0;
      err_count  <= 8'd0;
      first_fail <= 2'b00;
      pass       <= 1'b0;
    end else if (sample) begin
      vec        <= vec + 2'd1;
      settle_cnt <= SETTLE_LOAD;
      if (vec == 2'b11 && !last_vec) loop_cnt <= loop_cnt + 8'd1;
      if (mismatch) begin
        if (err_count != 8'hff) err_count <= err_count + 8'd1;
        if (err_count == 8'd0)  first_fail <= vec;
      end
      // pass must include the sample taken on this final edge
      if (last_vec) pass <= (err_count == 8'd0) && !mismatch;
    end else if (state == HOLD) begin
      settle_cnt <= settle_cnt - 4'd1;
    end else if (state == DONE) begin
      settle_cnt <= 4'd0;
      loop_cnt   <= 8'd0;
    end
  end

`ifdef XNOR_BIST_FAIL_MASK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      fail_mask      <= 4'b0000;
    else if (accept)              fail_mask      <= 4'b0000;
    else if (sample && mismatch)  fail_mask[vec] <= 1'b1;
  end
`endif

endmodule
